// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Monitors a multiplexed common-anode 7-segment bus and rebuilds the BCD digits
// it shows. Each {anode,segment} pair must be seen unchanged on STABLE_CYC
// consecutive edges before it is accepted. Each accepted pair is decoded back to
// a BCD nibble for the selected digit. Ghosting and glitches during digit
// switching are therefore ignored. Illegal segment codes and overlapping anodes
// are reported as one-cycle error pulses.
module seg7_scan_reader #(
   parameter int N_DIG      = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           seg_in,
   input  logic [N_DIG-1:0]     an_in,
   input  logic                 clear,
   output logic [4*N_DIG-1:0]   bcd_out,
   output logic [N_DIG-1:0]     digit_valid,
   output logic                 frame_valid,
   output logic                 err_pattern,
   output logic                 err_anode
);

   localparam int PW = N_DIG + 7;

   // The counter saturates at STABLE_CYC, so a held pair commits exactly once.
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
   localparam logic [7:0] CNT_HIT = 8'(STABLE_CYC - 1);

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ONE,
      SEL_MULTI
   } sel_e;

   typedef enum logic [1:0] {
      CODE_DIGIT,
      CODE_BLANK,
      CODE_BAD
   } code_e;

   logic [PW-1:0] pair;
   logic [PW-1:0] smp;
   logic [7:0]    cnt;
   logic          same;
   logic          commit;
   sel_e          sel;
   code_e         code;
   logic [3:0]    seg_val;

   assign pair   = {an_in, seg_in};
   assign same   = (pair == smp);
   assign commit = same && (cnt == CNT_HIT);

   // Classify the anode bus as no digit, exactly one digit, or an overlap.
   always_comb begin
      logic found;
      logic multi;
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves a value held and no latch is inferred.
      found = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < N_DIG; i++) begin
         if (!an_in[i]) begin
            if (found) multi = 1'b1;
            found = 1'b1;
         end
      end
      if (multi)      sel = SEL_MULTI;
      else if (found) sel = SEL_ONE;
      else            sel = SEL_NONE;
   end

   // Invert the BCD->7seg table (active-low segments {g,f,e,d,c,b,a}).
   always_comb begin
      seg_val = 4'hF;
      code    = CODE_DIGIT;
      case (seg_in)
         7'h40:   seg_val = 4'd0;
         7'h79:   seg_val = 4'd1;
         7'h24:   seg_val = 4'd2;
         7'h30:   seg_val = 4'd3;
         7'h19:   seg_val = 4'd4;
         7'h12:   seg_val = 4'd5;
         7'h02:   seg_val = 4'd6;
         7'h78:   seg_val = 4'd7;
         7'h00:   seg_val = 4'd8;
         7'h10:   seg_val = 4'd9;
         7'h7F:   code    = CODE_BLANK;
         default: code    = CODE_BAD;
      endcase
   end

   // Sample the bus every edge and count how long the pair has held steady.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp <= '1;
         cnt <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register
         // updates from pre-edge values, independent of statement order.
         smp <= pair;
         if (clear)              cnt <= '0;
         else if (!same)         cnt <= 8'd1;
         else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      end
   end

   // Apply accepted pairs to the digit store and raise the error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_out     <= '1;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
      end else begin
         err_pattern <= 1'b0;
         err_anode   <= 1'b0;
         if (clear) begin
            // A clear wins over a coincident commit; that commit is lost.
            bcd_out     <= '1;
            digit_valid <= '0;
            frame_valid <= 1'b0;
         end else begin
            frame_valid <= &digit_valid;
            if (commit) begin
               case (sel)
                  SEL_ONE: begin
                     if (code == CODE_BAD) begin
                        err_pattern <= 1'b1;
                     end else begin
                        for (int k = 0; k < N_DIG; k++) begin
                           if (!an_in[k]) begin
                              bcd_out[4*k +: 4] <= seg_val;
                              digit_valid[k]    <= (code == CODE_DIGIT);
                           end
                        end
                     end
                  end
                  SEL_MULTI: err_anode <= 1'b1;
                  default:   ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader. A run-length / lookup-table model predicts every
// output each cycle. Directed scenarios pin literal values. A randomized scan
// phase then exercises glitches, clears, blanks, bad codes and overlapping anodes.
module tb_seg7_scan_reader;

   localparam int N_DIG      = 4;
   localparam int STABLE_CYC = 4;

   logic                clk    = 1'b0;
   logic                rst_n  = 1'b0;
   logic                clear  = 1'b0;
   logic [6:0]          seg_in = 7'h7F;
   logic [N_DIG-1:0]    an_in  = '1;
   logic [4*N_DIG-1:0]  bcd_out;
   logic [N_DIG-1:0]    digit_valid;
   logic                frame_valid;
   logic                err_pattern;
   logic                err_anode;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   always #5 clk = ~clk;

   seg7_scan_reader #(.N_DIG(N_DIG), .STABLE_CYC(STABLE_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .an_in       (an_in),
      .clear       (clear),
      .bcd_out     (bcd_out),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .err_pattern (err_pattern),
      .err_anode   (err_anode)
   );

   // Behavioural model: length of the current run of identical samples.
   logic [N_DIG+6:0] m_last;
   int               m_run;
   logic [3:0]       m_dig [N_DIG];
   logic [N_DIG-1:0] m_val;
   logic             m_fv, m_ep, m_ea;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_last = '1;
         m_run  = 0;
         for (int k = 0; k < N_DIG; k++) m_dig[k] = 4'hF;
         m_val = '0;
         m_fv  = 1'b0;
         m_ep  = 1'b0;
         m_ea  = 1'b0;
      end else begin
         int nsel;
         int value;
         m_ep = 1'b0;
         m_ea = 1'b0;
         if (clear) begin
            for (int k = 0; k < N_DIG; k++) m_dig[k] = 4'hF;
            m_val = '0;
            m_fv  = 1'b0;
            m_run = 0;
         end else begin
            m_fv  = &m_val;
            m_run = ({an_in, seg_in} == m_last) ? m_run + 1 : 1;
            if (m_run == STABLE_CYC) begin
               nsel = $countones(~an_in);
               if (nsel > 1) begin
                  m_ea = 1'b1;
               end else if (nsel == 1) begin
                  value = -1;
                  for (int v = 0; v < 10; v++) if (codes[v] == seg_in) value = v;
                  for (int k = 0; k < N_DIG; k++) begin
                     if (!an_in[k]) begin
                        if (value >= 0) begin
                           m_dig[k] = 4'(value);
                           m_val[k] = 1'b1;
                        end else if (seg_in == 7'h7F) begin
                           m_dig[k] = 4'hF;
                           m_val[k] = 1'b0;
                        end else begin
                           m_ep = 1'b1;
                        end
                     end
                  end
               end
            end
         end
         m_last = {an_in, seg_in};
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      logic [4*N_DIG-1:0] eb;
      for (int k = 0; k < N_DIG; k++) eb[4*k +: 4] = m_dig[k];
      n_cmp++;
      if ({bcd_out, digit_valid, frame_valid, err_pattern, err_anode} !==
          {eb, m_val, m_fv, m_ep, m_ea}) begin
         n_bad++;
         $display("FAIL model_cmp @%0t: got bcd=%h dv=%b fv=%b ep=%b ea=%b, expected bcd=%h dv=%b fv=%b ep=%b ea=%b",
                  $time, bcd_out, digit_valid, frame_valid, err_pattern, err_anode,
                  eb, m_val, m_fv, m_ep, m_ea);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input logic [N_DIG-1:0] an, input logic [6:0] seg);
      an_in  = an;
      seg_in = seg;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N_DIG-1:0] an;
      logic [6:0]       seg;
      int               r;
      int               hold;

      #12;
      check("reset_bcd", 32'(bcd_out), 32'hFFFF);
      check("reset_dv",  32'(digit_valid), 32'h0);
      check("reset_flags", {29'd0, frame_valid, err_pattern, err_anode}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(1);

      // Single digit qualifies on the 4th edge, not the 3rd.
      drive(4'b1110, 7'h24);
      cycles(3);
      check("t1_dv_edge3", 32'(digit_valid), 32'h0);
      cycles(1);
      check("t1_nib_edge4", 32'(bcd_out[3:0]), 32'h2);
      check("t1_dv_edge4", 32'(digit_valid), 32'h1);

      // Full scan 1,2,3,4; frame_valid one edge after last commit.
      for (int d = 0; d < N_DIG; d++) begin
         an = ~(4'b0001 << d);
         drive(an, codes[d+1]);
         if (d == N_DIG - 1) begin
            cycles(4);
            check("t2_dv_full", 32'(digit_valid), 32'hF);
            check("t2_fv_late", 32'(frame_valid), 32'h0);
            cycles(1);
            check("t2_fv_set", 32'(frame_valid), 32'h1);
            cycles(1);
         end else begin
            cycles(6);
         end
      end
      check("t2_bcd", 32'(bcd_out), 32'h4321);

      // Short glitch value never lands.
      drive(4'b1110, 7'h24);
      cycles(2);
      drive(4'b1110, 7'h30);
      cycles(3);
      check("t3_no_glitch", 32'(bcd_out[3:0]), 32'h1);
      cycles(1);
      check("t3_nib", 32'(bcd_out[3:0]), 32'h3);

      // Illegal pattern and overlapping anodes.
      drive(4'b1101, 7'h55);
      cycles(4);
      check("t4_err_pattern", 32'(err_pattern), 32'h1);
      check("t4_dig1_kept", 32'(bcd_out[7:4]), 32'h2);
      cycles(1);
      check("t4_err_pattern_pulse", 32'(err_pattern), 32'h0);
      drive(4'b1100, 7'h40);
      cycles(4);
      check("t4_err_anode", 32'(err_anode), 32'h1);
      check("t4_bcd_kept", 32'(bcd_out), 32'h4323);
      cycles(1);
      check("t4_err_anode_pulse", 32'(err_anode), 32'h0);

      // Blank on a valid digit.
      drive(4'b1110, 7'h7F);
      cycles(4);
      check("t5_nib_blank", 32'(bcd_out[3:0]), 32'hF);
      check("t5_dv", 32'(digit_valid), 32'hE);
      cycles(1);
      check("t5_fv_drop", 32'(frame_valid), 32'h0);

      // Clear coincident with commit, then re-commit.
      drive(4'b1110, 7'h40);
      cycles(3);
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      check("t6_clear_bcd", 32'(bcd_out), 32'hFFFF);
      check("t6_clear_dv", 32'({digit_valid, frame_valid}), 32'h0);
      cycles(3);
      check("t6_recommit_early", 32'(digit_valid), 32'h0);
      cycles(1);
      check("t6_recommit_dv", 32'(digit_valid), 32'h1);
      check("t6_recommit_nib", 32'(bcd_out[3:0]), 32'h0);

      // Reset mid-window.
      drive(4'b1011, 7'h12);
      cycles(2);
      rst_n = 1'b0;
      #1;
      check("t6_rst_bcd", 32'(bcd_out), 32'hFFFF);
      check("t6_rst_dv", 32'(digit_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(3);
      check("t6_rst_requal_early", 32'(bcd_out[11:8]), 32'hF);
      cycles(1);
      check("t6_rst_requal", 32'(bcd_out[11:8]), 32'h5);

      // Randomized scan traffic.
      repeat (400) begin
         r = $urandom_range(0, 99);
         if (r < 75)      an = ~(4'b0001 << $urandom_range(0, N_DIG - 1));
         else if (r < 85) an = '1;
         else             an = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 99);
         if (r < 70)      seg = codes[$urandom_range(0, 9)];
         else if (r < 80) seg = 7'h7F;
         else             seg = 7'($urandom_range(0, 127));
         drive(an, seg);
         hold = $urandom_range(1, 7);
         for (int c = 0; c < hold; c++) begin
            clear = ($urandom_range(0, 29) == 0);
            cycles(1);
         end
         clear = 1'b0;
      end
      cycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
